// File: rtl/fproc_arb_pkg.sv
// fproc_arb_pkg: shared types and helpers for the fproc arbiter.
// Holds the arbiter FSM state encoding and an index-width helper that never
// returns zero, so one-entry counters and vectors stay legal.
package fproc_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fproc_arbiter_rr_picker.sv
// rr_picker: combinational round-robin priority encoder.
// Ports: pending (request vector), last (previous grant) -> grant (first set
// index after last, wrapping), any (some request is pending).
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  pending,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] grant,
  output logic          any
);
  always_comb begin
    grant = last;
    for (int k = N; k >= 1; k--)
      if (pending[(int'(last) + k) % N]) grant = IW'((int'(last) + k) % N);
  end
  assign any = |pending;
endmodule

// File: rtl/fproc_arbiter.sv
// fproc_arbiter: shares one function processor among N_CORES proc cores.
// Ports: clk, reset (async active-low); core_req_en/core_req_id per-core
// request pulses; core_ready/core_data per-core response; fproc_req_* request
// handshake to the shared fproc; fproc_resp_* its result; busy, timeout_err,
// dup_err status.
module fproc_arbiter import fproc_arb_pkg::*; #(
  parameter int N_CORES        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_CORES-1:0]            core_req_en,
  input  logic [N_CORES*ID_WIDTH-1:0]   core_req_id,
  output logic [N_CORES-1:0]            core_ready,
  output logic [DATA_WIDTH-1:0]         core_data,
  output logic                          fproc_req_valid,
  output logic [ID_WIDTH-1:0]           fproc_req_id,
  output logic [$clog2(N_CORES)-1:0]    fproc_req_core,
  input  logic                          fproc_req_ack,
  input  logic                          fproc_resp_valid,
  input  logic [DATA_WIDTH-1:0]         fproc_resp_data,
  output logic                          busy,
  output logic                          timeout_err,
  output logic                          dup_err
);
  localparam int IW = $clog2(N_CORES);
  localparam int CW = idx_w(TIMEOUT_CYCLES);
  state_t                state, state_n;
  logic [N_CORES-1:0]    pending, clr, load, dup;
  logic [ID_WIDTH-1:0]   id_q [N_CORES];
  logic [IW-1:0]         g, last_grant, pick;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] resp_q;
  logic                  any, tmo;
  rr_picker #(.N(N_CORES), .IW(IW)) u_pick (
    .pending(pending),
    .last(last_grant),
    .grant(pick),
    .any(any)
  );
  assign clr  = (state == RESP) ? (N_CORES'(1) << g) : '0;
  // a pulse landing on the core's own RESP cycle re-arms it with the new id
  assign load = core_req_en & (~pending | clr);
  assign dup  = core_req_en & pending & ~clr;
  assign tmo  = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign core_ready      = clr;
  assign core_data       = resp_q;
  assign busy            = state != IDLE;
  assign fproc_req_valid = state == ISSUE;
  assign fproc_req_id    = (state == ISSUE) ? id_q[g] : '0;
  assign fproc_req_core  = (state == ISSUE) ? g : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  state_n = any ? ISSUE : IDLE;
      ISSUE: state_n = fproc_req_ack ? WAIT : ISSUE;
      WAIT:  state_n = (fproc_resp_valid || tmo) ? RESP : WAIT;
      RESP:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pending     <= '0;
      g           <= '0;
      last_grant  <= IW'(N_CORES - 1);
      cnt         <= '0;
      resp_q      <= '0;
      timeout_err <= 1'b0;
      dup_err     <= 1'b0;
      for (int i = 0; i < N_CORES; i++) id_q[i] <= '0;
    end else begin
      pending <= (pending & ~clr) | core_req_en;
      for (int i = 0; i < N_CORES; i++)
        if (load[i]) id_q[i] <= core_req_id[i*ID_WIDTH +: ID_WIDTH];
      if (|dup) dup_err <= 1'b1;
      if (state == IDLE && any) g <= pick;
      if (state == WAIT) begin
        cnt <= cnt + 1'b1;
        if (fproc_resp_valid) resp_q <= fproc_resp_data;
        else if (tmo) begin
          resp_q      <= '0;
          timeout_err <= 1'b1;
        end
      end
      if (state == RESP) begin
        last_grant <= g;
        cnt        <= '0;
      end
    end
endmodule

// File: tb/tb_fproc_arbiter.sv
// tb_fproc_arbiter: directed self-checking bench for fproc_arbiter.
module tb_fproc_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  core_req_en = '0;
  logic [31:0] core_req_id = '0;
  logic [3:0]  core_ready;
  logic [31:0] core_data;
  logic        fproc_req_valid;
  logic [7:0]  fproc_req_id;
  logic [1:0]  fproc_req_core;
  logic        fproc_req_ack = 1'b0;
  logic        fproc_resp_valid = 1'b0;
  logic [31:0] fproc_resp_data = '0;
  logic        busy, timeout_err, dup_err;
  int          checks = 0, errors = 0, xfers = 0;

  fproc_arbiter #(.N_CORES(4), .DATA_WIDTH(32), .ID_WIDTH(8), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk),
    .reset(reset),
    .core_req_en(core_req_en),
    .core_req_id(core_req_id),
    .core_ready(core_ready),
    .core_data(core_data),
    .fproc_req_valid(fproc_req_valid),
    .fproc_req_id(fproc_req_id),
    .fproc_req_core(fproc_req_core),
    .fproc_req_ack(fproc_req_ack),
    .fproc_resp_valid(fproc_resp_valid),
    .fproc_resp_data(fproc_resp_data),
    .busy(busy),
    .timeout_err(timeout_err),
    .dup_err(dup_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (fproc_req_valid && fproc_req_ack) xfers <= xfers + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] m, input logic [31:0] ids);
    core_req_en = m;
    core_req_id = ids;
    tick();
    core_req_en = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Wait for a grant, hold ack low for `hold` cycles, respond `rdly` cycles
  // after the ack cycle, and optionally pulse cores `im` on the RESP cycle.
  task automatic serve(input int c, input logic [7:0] id, input int hold, input int rdly,
                       input logic [31:0] d, input logic [3:0] im, input logic [31:0] iid);
    int n;
    int x0;
    n = 0;
    while (!fproc_req_valid && n < 20) begin
      tick();
      n++;
    end
    x0 = xfers;
    for (int k = 0; k < hold; k++) begin
      chk("hold_valid", {31'd0, fproc_req_valid}, 32'd1);
      chk("hold_core", {30'd0, fproc_req_core}, c);
      chk("hold_id", {24'd0, fproc_req_id}, {24'd0, id});
      tick();
    end
    chk("req_valid", {31'd0, fproc_req_valid}, 32'd1);
    chk("req_core", {30'd0, fproc_req_core}, c);
    chk("req_id", {24'd0, fproc_req_id}, {24'd0, id});
    chk("no_early_xfer", xfers, x0);
    fproc_req_ack = 1'b1;
    tick();
    fproc_req_ack = 1'b0;
    chk("valid_drop", {31'd0, fproc_req_valid}, 32'd0);
    chk("one_xfer", xfers, x0 + 1);
    repeat (rdly - 1) tick();
    fproc_resp_valid = 1'b1;
    fproc_resp_data = d;
    tick();
    fproc_resp_valid = 1'b0;
    fproc_resp_data = '0;
    core_req_en = im;
    core_req_id = iid;
    chk("core_ready", {28'd0, core_ready}, 32'(1) << c);
    chk("core_data", core_data, d);
    tick();
    core_req_en = '0;
    chk("ready_drop", {28'd0, core_ready}, 32'd0);
    chk("single_xfer", xfers, x0 + 1);
  endtask

  initial begin
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, fproc_req_valid}, 32'd0);
    chk("rst_ready", {28'd0, core_ready}, 32'd0);
    chk("rst_data", core_data, 32'd0);
    chk("rst_errs", {30'd0, timeout_err, dup_err}, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    pulse(4'b0100, 32'h0015_0000);
    chk("t1_not_yet", {31'd0, fproc_req_valid}, 32'd0);
    tick();
    chk("t1_valid_t2", {31'd0, fproc_req_valid}, 32'd1);
    serve(2, 8'h15, 0, 3, 32'hDEADBEEF, 4'b0000, 32'd0);
    chk("t1_idle", {31'd0, busy}, 32'd0);

    do_reset();
    pulse(4'b1011, 32'hA300_A1A0);
    serve(0, 8'hA0, 0, 2, 32'h1111_0000, 4'b0000, 32'd0);
    serve(1, 8'hA1, 0, 2, 32'h2222_0001, 4'b0000, 32'd0);
    serve(3, 8'hA3, 0, 2, 32'h3333_0003, 4'b0001, 32'h0000_00B0);
    serve(0, 8'hB0, 0, 2, 32'h4444_0000, 4'b0000, 32'd0);

    pulse(4'b0010, 32'h0000_5A00);
    serve(1, 8'h5A, 7, 2, 32'hCAFE_F00D, 4'b0000, 32'd0);

    pulse(4'b0001, 32'h0000_000C);
    serve(0, 8'h0C, 0, 8, 32'h1234_5678, 4'b0000, 32'd0);
    chk("boundary_no_tmo", {31'd0, timeout_err}, 32'd0);

    pulse(4'b1000, 32'h3300_0000);
    tick();
    chk("tmo_valid", {31'd0, fproc_req_valid}, 32'd1);
    fproc_req_ack = 1'b1;
    tick();
    fproc_req_ack = 1'b0;
    repeat (7) tick();
    chk("tmo_early_ready", {28'd0, core_ready}, 32'd0);
    chk("tmo_early_err", {31'd0, timeout_err}, 32'd0);
    tick();
    chk("tmo_ready", {28'd0, core_ready}, 32'h8);
    chk("tmo_data", core_data, 32'd0);
    chk("tmo_err", {31'd0, timeout_err}, 32'd1);
    tick();
    tick();
    chk("tmo_sticky", {31'd0, timeout_err}, 32'd1);
    chk("tmo_idle", {31'd0, busy}, 32'd0);

    chk("dup_clean", {31'd0, dup_err}, 32'd0);
    pulse(4'b0010, 32'h0000_1100);
    pulse(4'b0010, 32'h0000_2200);
    chk("dup_err", {31'd0, dup_err}, 32'd1);
    serve(1, 8'h11, 0, 2, 32'h5555_AAAA, 4'b0000, 32'd0);
    repeat (5) tick();
    chk("dup_no_second", {31'd0, busy}, 32'd0);
    chk("dup_no_valid", {31'd0, fproc_req_valid}, 32'd0);

    pulse(4'b0010, 32'h0000_4400);
    serve(1, 8'h44, 0, 2, 32'h0000_0044, 4'b0010, 32'h0000_5500);
    serve(1, 8'h55, 0, 2, 32'h0000_0055, 4'b0000, 32'd0);

    pulse(4'b0100, 32'h0077_0000);
    tick();
    fproc_req_ack = 1'b1;
    tick();
    fproc_req_ack = 1'b0;
    chk("mid_wait", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_valid", {31'd0, fproc_req_valid}, 32'd0);
    chk("mid_id", {22'd0, fproc_req_core, fproc_req_id}, 32'd0);
    chk("mid_ready", {28'd0, core_ready}, 32'd0);
    chk("mid_data", core_data, 32'd0);
    chk("mid_errs", {30'd0, timeout_err, dup_err}, 32'd0);
    fproc_resp_valid = 1'b1;
    fproc_resp_data = 32'hBAD0_BAD0;
    tick();
    reset = 1'b1;
    tick();
    fproc_resp_valid = 1'b0;
    fproc_resp_data = '0;
    for (int k = 0; k < 4; k++) begin
      chk("post_rst_ready", {28'd0, core_ready}, 32'd0);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      tick();
    end
    chk("post_rst_data", core_data, 32'd0);
    pulse(4'b0010, 32'h0000_9900);
    serve(1, 8'h99, 0, 2, 32'h9999_0001, 4'b0000, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
